// File: rtl/ray_tracer_pkg.sv
// Shared widths, FSM states, colours and object-field helpers for the sequential ray tracer.
package ray_tracer_pkg;

    typedef enum logic [2:0] {StIdle, StPrep, StDot, StCmp, StShade, StDone} state_e;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hfff;

    function automatic int unsigned obj_w(input int unsigned cw);
        return 4 * cw + 12;
    endfunction

    function automatic int unsigned key_w(input int unsigned cw);
        return 2 * cw + 3;
    endfunction

    function automatic int unsigned c_w(input int unsigned cw);
        return 2 * cw + 4;
    endfunction

    function automatic int unsigned disc_w(input int unsigned cw);
        return 4 * cw + 8;
    endfunction

    function automatic int unsigned dd_w(input int unsigned cw);
        return 2 * cw + 2;
    endfunction

    // Object word layout, LSB first: cx, cy, cz, r, color[11:0].
    function automatic int unsigned cx_lsb(input int unsigned cw);
        return 0;
    endfunction

    function automatic int unsigned cy_lsb(input int unsigned cw);
        return cw;
    endfunction

    function automatic int unsigned cz_lsb(input int unsigned cw);
        return 2 * cw;
    endfunction

    function automatic int unsigned r_lsb(input int unsigned cw);
        return 3 * cw;
    endfunction

    function automatic int unsigned color_lsb(input int unsigned cw);
        return 4 * cw;
    endfunction

endpackage

// File: rtl/ray_sphere_step.sv
// Two-stage ray/sphere test: DOT registers b and c, CMP evaluates the discriminant from them.
module ray_sphere_step import ray_tracer_pkg::*; #(
    parameter int unsigned COORD_W = 10,
    localparam int unsigned KEY_W  = key_w(COORD_W),
    localparam int unsigned C_W    = c_w(COORD_W),
    localparam int unsigned DISC_W = disc_w(COORD_W),
    localparam int unsigned DD_W   = dd_w(COORD_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   obj_valid,
    input  logic [COORD_W-1:0]     cx,
    input  logic [COORD_W-1:0]     cy,
    input  logic [COORD_W-1:0]     cz,
    input  logic [COORD_W-1:0]     r,
    input  logic [3*COORD_W-1:0]   init,
    input  logic [3*COORD_W-1:0]   dir,
    input  logic [DD_W-1:0]        dd,
    output logic                   cand,
    output logic [KEY_W-1:0]       key
);

    logic signed [COORD_W:0]   ocx, ocy, ocz;
    logic signed [COORD_W-1:0] dx, dy, dz;
    logic signed [KEY_W-1:0]   b_d, b_q;
    logic signed [C_W-1:0]     c_d, c_q;
    logic signed [DISC_W-1:0]  disc;
    logic                      valid_q;

    always_comb begin
        dx  = $signed(dir[0 +: COORD_W]);
        dy  = $signed(dir[COORD_W +: COORD_W]);
        dz  = $signed(dir[2*COORD_W +: COORD_W]);
        ocx = $signed({cx[COORD_W-1], cx})
            - $signed({init[COORD_W-1], init[0 +: COORD_W]});
        ocy = $signed({cy[COORD_W-1], cy})
            - $signed({init[2*COORD_W-1], init[COORD_W +: COORD_W]});
        ocz = $signed({cz[COORD_W-1], cz})
            - $signed({init[3*COORD_W-1], init[2*COORD_W +: COORD_W]});
        b_d = KEY_W'(ocx) * KEY_W'(dx) + KEY_W'(ocy) * KEY_W'(dy) + KEY_W'(ocz) * KEY_W'(dz);
        c_d = C_W'(ocx) * C_W'(ocx) + C_W'(ocy) * C_W'(ocy) + C_W'(ocz) * C_W'(ocz)
            - C_W'($signed({1'b0, r})) * C_W'($signed({1'b0, r}));
        disc = DISC_W'(b_q) * DISC_W'(b_q) - DISC_W'($signed(dd)) * DISC_W'(c_q);
        cand = valid_q && !disc[DISC_W-1] && !b_q[KEY_W-1] && (b_q != '0);
        key  = b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            b_q     <= b_d;
            c_q     <= c_d;
            valid_q <= obj_valid;
        end
    end

endmodule

// File: rtl/ray_tracer_seq.sv
// Sequential nearest-sphere tracer with RGB444 shading; RAY_TRACER_SHADE_DEPTH_EN enables depth dimming.
module ray_tracer_seq import ray_tracer_pkg::*; #(
    parameter int unsigned NUM_OBJ   = 8,
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned COLL_EPS  = 16,
    parameter logic [11:0] BG_COLOR  = BLACK,
    parameter int unsigned DEPTH_LSB = 6,
    localparam int unsigned OBJ_W    = obj_w(COORD_W),
    localparam int unsigned KEY_W    = key_w(COORD_W),
    localparam int unsigned DD_W     = dd_w(COORD_W),
    localparam int unsigned IDX_W    = $clog2(NUM_OBJ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_OBJ*OBJ_W-1:0] in_bus,
    input  logic [NUM_OBJ-1:0]       obj_en,
    input  logic [3*COORD_W-1:0]     init,
    input  logic [3*COORD_W-1:0]     dir,
    output logic                     busy,
    output logic                     tracer_ret,
    output logic                     hit,
    output logic [IDX_W-1:0]         hit_id,
    output logic [KEY_W-1:0]         hit_key,
    output logic                     collision_sig,
    output logic [11:0]              dout
);

    state_e                   state;
    logic [IDX_W-1:0]         k, best_id;
    logic [NUM_OBJ*OBJ_W-1:0] obj_q;
    logic [NUM_OBJ-1:0]       en_q;
    logic [3*COORD_W-1:0]     init_q, dir_q;
    logic [DD_W-1:0]          dd_q;
    logic [KEY_W-1:0]         best_key, step_key;
    logic                     best_valid, step_cand;
    logic [OBJ_W-1:0]         cur_obj, best_obj;
    logic [11:0]              best_color, shaded;
    logic signed [COORD_W-1:0] dx, dy, dz;
    logic signed [DD_W-1:0]   dd_d;
    logic [KEY_W-1:0]         depth;
    logic [1:0]               shift;

    always_comb begin
        cur_obj    = obj_q[32'(k) * OBJ_W +: OBJ_W];
        best_obj   = obj_q[32'(best_id) * OBJ_W +: OBJ_W];
        best_color = best_obj[color_lsb(COORD_W) +: 12];
        dx   = $signed(dir_q[0 +: COORD_W]);
        dy   = $signed(dir_q[COORD_W +: COORD_W]);
        dz   = $signed(dir_q[2*COORD_W +: COORD_W]);
        dd_d = DD_W'(dx) * DD_W'(dx) + DD_W'(dy) * DD_W'(dy) + DD_W'(dz) * DD_W'(dz);
        // Keys of stored hits are always positive, so unsigned shifts and compares are safe.
        depth = best_key >> DEPTH_LSB;
        shift = (depth > KEY_W'(3)) ? 2'd3 : depth[1:0];
`ifdef RAY_TRACER_SHADE_DEPTH_EN
        shaded = {best_color[11:8] >> shift, best_color[7:4] >> shift, best_color[3:0] >> shift};
`else
        shaded = best_color;
`endif
    end

    ray_sphere_step #(
        .COORD_W(COORD_W)
    ) u_step (
        .clk      (clk),
        .rst      (rst),
        .load     (state == StDot),
        .obj_valid(en_q[k]),
        .cx       (cur_obj[cx_lsb(COORD_W) +: COORD_W]),
        .cy       (cur_obj[cy_lsb(COORD_W) +: COORD_W]),
        .cz       (cur_obj[cz_lsb(COORD_W) +: COORD_W]),
        .r        (cur_obj[r_lsb(COORD_W) +: COORD_W]),
        .init     (init_q),
        .dir      (dir_q),
        .dd       (dd_q),
        .cand     (step_cand),
        .key      (step_key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            k             <= '0;
            obj_q         <= '0;
            en_q          <= '0;
            init_q        <= '0;
            dir_q         <= '0;
            dd_q          <= '0;
            best_valid    <= 1'b0;
            best_key      <= '0;
            best_id       <= '0;
            busy          <= 1'b0;
            tracer_ret    <= 1'b0;
            hit           <= 1'b0;
            hit_id        <= '0;
            hit_key       <= '0;
            collision_sig <= 1'b0;
            dout          <= BG_COLOR;
        end else begin
            tracer_ret <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        obj_q  <= in_bus;
                        en_q   <= obj_en;
                        init_q <= init;
                        dir_q  <= dir;
                        busy   <= 1'b1;
                        state  <= StPrep;
                    end
                end
                StPrep: begin
                    dd_q       <= dd_d;
                    best_valid <= 1'b0;
                    k          <= '0;
                    state      <= StDot;
                end
                StDot: state <= StCmp;
                StCmp: begin
                    // Strict compare keeps the lower index on equal keys.
                    if (step_cand && (!best_valid || step_key < best_key)) begin
                        best_valid <= 1'b1;
                        best_key   <= step_key;
                        best_id    <= k;
                    end
                    if (k == IDX_W'(NUM_OBJ - 1)) begin
                        state <= StShade;
                    end else begin
                        k     <= k + IDX_W'(1);
                        state <= StDot;
                    end
                end
                StShade: begin
                    hit           <= best_valid;
                    hit_id        <= best_valid ? best_id : '0;
                    hit_key       <= best_valid ? best_key : '0;
                    collision_sig <= best_valid && (best_key < KEY_W'(COLL_EPS));
                    dout          <= best_valid ? shaded : BG_COLOR;
                    tracer_ret    <= 1'b1;
                    state         <= StDone;
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_tracer_seq.sv
// Directed self-checking bench for ray_tracer_seq (NUM_OBJ=8, COORD_W=10).
module tb_ray_tracer_seq;

    localparam int NUM_OBJ = 8;
    localparam int W       = 10;
    localparam int OBJ_W   = 4 * W + 12;
    localparam int KEY_W   = 2 * W + 3;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic [NUM_OBJ*OBJ_W-1:0] in_bus = '0;
    logic [NUM_OBJ-1:0]       obj_en = '0;
    logic [3*W-1:0]           init = '0;
    logic [3*W-1:0]           dir = '0;
    logic                     busy, tracer_ret, hit, collision_sig;
    logic [2:0]               hit_id;
    logic [KEY_W-1:0]         hit_key;
    logic [11:0]              dout;

    int errors = 0;
    int checks = 0;
    int lat;
    int pulses;

    ray_tracer_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_bus       (in_bus),
        .obj_en       (obj_en),
        .init         (init),
        .dir          (dir),
        .busy         (busy),
        .tracer_ret   (tracer_ret),
        .hit          (hit),
        .hit_id       (hit_id),
        .hit_key      (hit_key),
        .collision_sig(collision_sig),
        .dout         (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_obj(input int i, input int x, input int y, input int z, input int r,
                           input logic [11:0] col);
        in_bus[i*OBJ_W +: OBJ_W] = {col, W'(r), W'(z), W'(y), W'(x)};
    endtask

    // Pulses start, optionally re-pulses it at E0+restart_at or drops obj_en after E0,
    // and returns the edge count after E0 at which tracer_ret was seen (-1 on timeout).
    task automatic run_trace(input int restart_at, input bit clear_en, output int latency);
        latency = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 chk("busy_after_accept", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        if (clear_en) obj_en = '0;
        for (int n = 1; n <= 40; n++) begin
            start = (n == restart_at);
            @(posedge clk);
            #1;
            if (tracer_ret) begin
                latency = n;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("latency", 32'(latency), 32'd18);
        chk("busy_at_ret", 32'(busy), 32'd1);
        @(posedge clk);
        #1 chk("ret_one_cycle", 32'(tracer_ret), 32'd0);
        chk("busy_dropped", 32'(busy), 32'd0);
    endtask

    initial begin
        dir = {W'(1), W'(0), W'(0)};
        init = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ret", 32'(tracer_ret), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_dout", 32'(dout), 32'h000);
        @(negedge clk);
        rst = 1'b0;

        // 1: single sphere; obj_en is cleared after accept and must be ignored.
        set_obj(0, 0, 0, 100, 10, 12'hF00);
        obj_en = 8'b0000_0001;
        run_trace(0, 1'b1, lat);
        chk("t1_hit", 32'(hit), 32'd1);
        chk("t1_id", 32'(hit_id), 32'd0);
        chk("t1_key", 32'(hit_key), 32'd100);
        chk("t1_coll", 32'(collision_sig), 32'd0);
`ifdef RAY_TRACER_SHADE_DEPTH_EN
        chk("t1_dout", 32'(dout), 32'h700);
`else
        chk("t1_dout", 32'(dout), 32'hF00);
`endif

        // 2: nearest of two, with a second start at E0+5 that must not restart.
        in_bus = '0;
        set_obj(5, 0, 0, 200, 10, 12'h00F);
        set_obj(2, 0, 0, 50, 10, 12'h0F0);
        obj_en = 8'b0010_0100;
        run_trace(5, 1'b0, lat);
        chk("t2_hit", 32'(hit), 32'd1);
        chk("t2_id", 32'(hit_id), 32'd2);
        chk("t2_key", 32'(hit_key), 32'd50);
        chk("t2_dout", 32'(dout), 32'h0F0);
        pulses = 0;
        repeat (25) begin
            @(posedge clk);
            #1 if (tracer_ret || busy) pulses++;
        end
        chk("t2_no_restart", 32'(pulses), 32'd0);

        // 3: one sphere off-axis, one behind the origin.
        in_bus = '0;
        set_obj(1, 100, 0, 100, 10, 12'hFFF);
        set_obj(4, 0, 0, -100, 10, 12'hFFF);
        obj_en = 8'b0001_0010;
        run_trace(0, 1'b0, lat);
        chk("t3_hit", 32'(hit), 32'd0);
        chk("t3_id", 32'(hit_id), 32'd0);
        chk("t3_key", 32'(hit_key), 32'd0);
        chk("t3_dout", 32'(dout), 32'h000);
        chk("t3_coll", 32'(collision_sig), 32'd0);

        // 4: identical spheres in slots 3 and 6.
        in_bus = '0;
        set_obj(3, 0, 0, 60, 10, 12'h0A0);
        set_obj(6, 0, 0, 60, 10, 12'h0A0);
        obj_en = 8'b0100_1000;
        run_trace(0, 1'b0, lat);
        chk("t4_tie_id", 32'(hit_id), 32'd3);
        chk("t4_tie_key", 32'(hit_key), 32'd60);
        obj_en = 8'b0100_0000;
        run_trace(0, 1'b0, lat);
        chk("t4_en_id", 32'(hit_id), 32'd6);
        chk("t4_en_hit", 32'(hit), 32'd1);

        // 5: origin inside the sphere, key below the collision threshold.
        in_bus = '0;
        set_obj(0, 0, 0, 8, 10, 12'h123);
        obj_en = 8'b0000_0001;
        run_trace(0, 1'b0, lat);
        chk("t5_hit", 32'(hit), 32'd1);
        chk("t5_key", 32'(hit_key), 32'd8);
        chk("t5_coll", 32'(collision_sig), 32'd1);
        chk("t5_dout", 32'(dout), 32'h123);

        // 6: reset at E0+7 aborts the trace, then a fresh trace completes.
        in_bus = '0;
        set_obj(2, 0, 0, 100, 10, 12'hF00);
        obj_en = 8'b0000_0100;
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1 if (tracer_ret) pulses++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_hit", 32'(hit), 32'd0);
        chk("t6_key", 32'(hit_key), 32'd0);
        chk("t6_coll", 32'(collision_sig), 32'd0);
        chk("t6_dout", 32'(dout), 32'h000);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1 if (tracer_ret) pulses++;
        end
        chk("t6_no_ret", 32'(pulses), 32'd0);
        run_trace(0, 1'b0, lat);
        chk("t6_fresh_hit", 32'(hit), 32'd1);
        chk("t6_fresh_id", 32'(hit_id), 32'd2);
        chk("t6_fresh_key", 32'(hit_key), 32'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
